m_stage: RTL and testbench
==========================

# m_stage

Memory-access stage of the five-stage pipeline, directly downstream of the E/M pipeline register. Takes the instruction in M, decodes its load/store opcode, and performs byte/half/word accesses against an internal word-organised data memory. Produces sign- or zero-extended load data, then registers everything the write-back stage needs into an internal M/W register. Also exposes a per-cycle store-observation port for the bench's memory-write log.

## Interface
- DM_WORDS, 3072: data memory depth in 32-bit words; valid byte addresses are 0 to DM_WORDS*4-1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- halt  in  1  flush: clears the M/W register and suppresses the store in M this cycle.
- m_pc  in  32  PC of the instruction in M.
- m_instr  in  32  instruction in M; opcode = m_instr[31:26].
- m_aluResult  in  32  effective byte address for loads/stores; pass-through value otherwise.
- m_grf_rt  in  32  store data, already forwarded.
- m_new_instr  in  1  valid flag of the instruction in M.
- w_pc, w_instr, w_aluResult  out  32 each  registered copies for W.
- w_memData  out  32  registered, extended load result; 0 for non-loads.
- w_new_instr  out  1  registered valid flag.
- dm_we  out  1  combinational: a store commits at the next edge.
- dm_addr  out  32  combinational: word-aligned byte address of the committed store ({m_aluResult[31:2],2'b00}).
- dm_byteen  out  4  combinational byte enables; bit i covers bits [8i+7:8i].
- dm_wdata  out  32  combinational: full merged word written (old bytes kept in disabled lanes).

## Operation
- Decoded opcodes: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28. All others are non-memory and pass through.
- Word index = m_aluResult[31:2]. In range iff m_aluResult < DM_WORDS*4.
- Alignment: word accesses need addr[1:0]=0; half accesses need addr[0]=0; byte accesses are always aligned.
- Store enables:
  - sw: 4'b1111.
  - sh: 4'b0011 shifted by addr[1]*2.
  - sb: 4'b0001 shifted by addr[1:0].
- Store data lanes:
  - sh: rt[15:0] replicated to both halves.
  - sb: rt[7:0] replicated to all four bytes.
- dm_we = store & m_new_instr & in-range & aligned & !halt & !reset. When dm_we=0, dm_byteen=0 and dm_addr/dm_wdata are don't-care.
- Load read is combinational from the current word.
  - lw: whole word.
  - lh/lhu: half selected by addr[1], sign- or zero-extended.
  - lb/lbu: byte selected by addr[1:0], sign- or zero-extended.
  - Out-of-range or misaligned loads return 0 and the memory is untouched.
- M/W register loads all w_* outputs every edge unless reset or halt.

## Timing
- Reset (edge with reset=1):
  - All w_* outputs become 0.
  - Every memory word is cleared to 0.
  - No store commits.
- Store commits at the edge ending its M cycle. A load in M on the very next cycle reads the new value (no bypass needed; read is after write).
- Load latency: data is combinational in M and appears on w_memData one edge later.
- halt and reset both asserted: reset wins, and the result is identical anyway.
- reset asserted mid-stream discards the in-flight M instruction; its store does not commit.
- m_new_instr=0 (bubble): no store, but fields are still registered.
- Address wrap: none. Addresses ≥ DM_WORDS*4 are never aliased onto low words.

## Test plan
- Reset, then sw rt=0x12345678 to addr 0x10, then lw from 0x10:
  - dm_we=1, dm_byteen=4'b1111, dm_wdata=0x12345678 on the store cycle.
  - The next edge after the lw gives w_memData=0x12345678.
- sb rt=0xAB to 0x11, then sh rt=0xCDEF to 0x12, then lw 0x10 (memory preloaded 0x12345678):
  - Byte enables 4'b0010 then 4'b1100.
  - Final word 0xCDEFAB78.
- Word 0x20 = 0x80FF7F01:
  - lb 0x22 → 0xFFFFFFFF.
  - lbu 0x22 → 0x000000FF.
  - lh 0x22 → 0xFFFF80FF.
  - lhu 0x20 → 0x00007F01.
- sw to 0x13 (misaligned) and sw to DM_WORDS*4 (out of range):
  - dm_we=0 and memory unchanged.
  - lw from 0x13 → w_memData=0.
- halt=1 during a sw to 0x40:
  - No commit; all w_* outputs become 0.
  - Then reset during a pending sw: memory all zero, w_* outputs 0.

Source files
------------

// File: rtl/m_stage.sv
// m_stage -- memory-access stage of the five-stage pipeline.
//
// Decodes the load/store opcode of the instruction in M, performs byte/half/
// word accesses against an internal word-organised data memory, extends load
// data, and registers everything write-back needs into the M/W register.
//
// There is no handshake on this stage: every cycle the instruction in M is
// consumed, and m_new_instr only marks whether it is a real instruction or a
// bubble (a bubble never stores but its fields are still registered).
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   halt                       flush: clears M/W and suppresses the store in M
//   m_pc, m_instr              PC and instruction in M (opcode = m_instr[31:26])
//   m_aluResult                effective byte address / pass-through value
//   m_grf_rt                   store data (already forwarded)
//   m_new_instr                valid flag of the instruction in M
//   w_pc, w_instr, w_aluResult registered copies for W
//   w_memData                  registered extended load data (0 for non-loads)
//   w_new_instr                registered valid flag
//   dm_we, dm_addr,            combinational store observation: the merged
//   dm_byteen, dm_wdata        word committed at the next edge
module m_stage #(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_aluResult,
  input  logic [31:0] m_grf_rt,
  input  logic        m_new_instr,
  output logic [31:0] w_pc,
  output logic [31:0] w_instr,
  output logic [31:0] w_aluResult,
  output logic [31:0] w_memData,
  output logic        w_new_instr,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_wdata
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic [31:0] mem [DM_WORDS];

  logic [5:0]    opcode;
  logic          is_load, is_store, is_word, is_half, is_byte, is_signed;
  logic          aligned, in_range;
  logic [1:0]    boff;
  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic [3:0]    store_be;
  logic [31:0]   lane_data;
  logic [31:0]   merged;
  logic [31:0]   load_data;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;

  assign opcode   = m_instr[31:26];
  assign boff     = m_aluResult[1:0];
  assign word_idx = m_aluResult[AW+1:2];
  // Unsigned compare on the full address: high addresses never alias low words.
  assign in_range = (m_aluResult < DM_BYTES);
  assign cur_word = in_range ? mem[word_idx] : '0;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_word   = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (opcode)
      OP_LW:  begin is_load = 1'b1; is_word = 1'b1; end
      OP_LH:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU: begin is_load = 1'b1; is_byte = 1'b1; end
      OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
  end

  assign aligned = is_word ? (boff == 2'b00) :
                   is_half ? (boff[0] == 1'b0) : 1'b1;

  // Byte enables and replicated store lanes.
  always_comb begin
    store_be  = 4'b0000;
    lane_data = m_grf_rt;
    if (is_word) begin
      store_be = 4'b1111;
    end else if (is_half) begin
      store_be  = boff[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{m_grf_rt[15:0]}};
    end else if (is_byte) begin
      store_be  = 4'b0001 << boff;
      lane_data = {4{m_grf_rt[7:0]}};
    end
  end

  // Read-modify-write merge: disabled lanes keep the current memory bytes.
  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (store_be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  assign dm_we     = is_store & m_new_instr & in_range & aligned & ~halt & ~reset;
  assign dm_byteen = dm_we ? store_be : 4'b0000;
  assign dm_addr   = {m_aluResult[31:2], 2'b00};
  assign dm_wdata  = merged;

  assign half_sel = boff[1] ? cur_word[31:16] : cur_word[15:0];
  assign byte_sel = cur_word[8*boff +: 8];

  // Out-of-range and misaligned loads return 0.
  always_comb begin
    load_data = '0;
    if (is_load && in_range && aligned) begin
      if (is_word)
        load_data = cur_word;
      else if (is_half)
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      else
        load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    end else if (dm_we) begin
      mem[word_idx] <= dm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || halt) begin
      w_pc        <= '0;
      w_instr     <= '0;
      w_aluResult <= '0;
      w_memData   <= '0;
      w_new_instr <= 1'b0;
    end else begin
      w_pc        <= m_pc;
      w_instr     <= m_instr;
      w_aluResult <= m_aluResult;
      w_memData   <= load_data;
      w_new_instr <= m_new_instr;
    end
  end

endmodule

// File: tb/tb_m_stage.sv
module tb_m_stage;

  localparam int DM_WORDS = 3072;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B,
                         NOP = 6'h00;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic [31:0] m_pc, m_instr, m_aluResult, m_grf_rt;
  logic        m_new_instr;
  logic [31:0] w_pc, w_instr, w_aluResult, w_memData;
  logic        w_new_instr;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  m_stage #(.DM_WORDS(DM_WORDS)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .m_pc(m_pc), .m_instr(m_instr), .m_aluResult(m_aluResult),
    .m_grf_rt(m_grf_rt), .m_new_instr(m_new_instr),
    .w_pc(w_pc), .w_instr(w_instr), .w_aluResult(w_aluResult),
    .w_memData(w_memData), .w_new_instr(w_new_instr),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_byteen(dm_byteen),
    .dm_wdata(dm_wdata)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        valid;
    logic        hlt;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_md;
  } vec_t;

  vec_t vecs[$];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic valid, input logic hlt, input logic rst, input int tag);
    @(negedge clk);
    reset       = rst;
    halt        = hlt;
    m_pc        = 32'h0000_3000 + 32'(tag * 4);
    m_instr     = {op, 26'(tag * 7 + 1)};
    m_aluResult = addr;
    m_grf_rt    = rt;
    m_new_instr = valid;
    #1;
  endtask

  task automatic check_comb(input string name, input logic exp_we, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] addr);
    check({name, ".dm_we"}, 32'(dm_we), 32'(exp_we));
    check({name, ".dm_byteen"}, 32'(dm_byteen), 32'(exp_be));
    if (exp_we) begin
      check({name, ".dm_wdata"}, dm_wdata, exp_wdata);
      check({name, ".dm_addr"}, dm_addr, {addr[31:2], 2'b00});
    end
  endtask

  // Advance one edge and compare the M/W register against the values captured
  // at drive time (all zero when flushed).
  task automatic check_w(input string name, input logic flushed);
    logic [31:0] e_pc, e_instr, e_alu, e_md;
    logic        e_v;
    e_pc    = flushed ? '0 : m_pc;
    e_instr = flushed ? '0 : m_instr;
    e_alu   = flushed ? '0 : m_aluResult;
    e_v     = flushed ? 1'b0 : m_new_instr;
    @(posedge clk);
    #1;
    e_md = exp_q.pop_front();
    check({name, ".w_memData"}, w_memData, e_md);
    check({name, ".w_pc"}, w_pc, e_pc);
    check({name, ".w_instr"}, w_instr, e_instr);
    check({name, ".w_aluResult"}, w_aluResult, e_alu);
    check({name, ".w_new_instr"}, 32'(w_new_instr), 32'(e_v));
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                     input logic valid, input logic hlt, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] md);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.valid = valid; v.hlt = hlt;
    v.exp_we = we; v.exp_be = be; v.exp_wdata = wd; v.exp_md = md;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    //   op   addr          rt            v  h  we  be       wdata         memData
    add(SW,  32'h10,       32'h12345678, 1, 0, 1, 4'b1111, 32'h12345678, 32'h0);
    add(LW,  32'h10,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h12345678);
    add(SB,  32'h11,       32'h000000AB, 1, 0, 1, 4'b0010, 32'h1234AB78, 32'h0);
    add(SH,  32'h12,       32'h0000CDEF, 1, 0, 1, 4'b1100, 32'hCDEFAB78, 32'h0);
    add(LW,  32'h10,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'hCDEFAB78);
    add(SW,  32'h20,       32'h80FF7F01, 1, 0, 1, 4'b1111, 32'h80FF7F01, 32'h0);
    add(LB,  32'h22,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'hFFFFFFFF);
    add(LBU, 32'h22,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h000000FF);
    add(LH,  32'h22,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'hFFFF80FF);
    add(LHU, 32'h20,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h00007F01);
    add(LB,  32'h20,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h00000001);
    add(LH,  32'h20,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h00007F01);
    add(SW,  32'h13,       32'hDEADBEEF, 1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(SW,  DM_WORDS * 4, 32'hDEADBEEF, 1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(SH,  32'h11,       32'h00001111, 1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h13,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h10,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'hCDEFAB78);
    add(LW,  DM_WORDS * 4, 32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h0,        32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LH,  32'h11,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LBU, 32'h13,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h000000CD);
    add(SW,  32'h30,       32'h11112222, 0, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h30,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(SW,  32'h40,       32'h55555555, 1, 1, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h40,       32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(NOP, 32'h00001234, 32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(LW,  32'h2FFC,     32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'h0);
    add(SW,  32'h2FFC,     32'hA5A5A5A5, 1, 0, 1, 4'b1111, 32'hA5A5A5A5, 32'h0);
    add(LW,  32'h2FFC,     32'h0,        1, 0, 0, 4'b0000, 32'h0,        32'hA5A5A5A5);

    reset = 1'b1; halt = 1'b0; m_pc = '0; m_instr = '0; m_aluResult = '0;
    m_grf_rt = '0; m_new_instr = 1'b0;

    // Reset: store attempted under reset never commits, w_* are zero.
    drive(SW, 32'h10, 32'hFFFFFFFF, 1, 0, 1, 0);
    check_comb("reset_sw", 0, 4'b0000, 32'h0, 32'h10);
    exp_q.push_back(32'h0);
    check_w("reset", 1);

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].valid, vecs[i].hlt, 0, i + 1);
      check_comb(nm, vecs[i].exp_we, vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].addr);
      exp_q.push_back(vecs[i].exp_md);
      check_w(nm, vecs[i].hlt);
    end

    // Reset during a pending sw: store suppressed, memory cleared.
    drive(SW, 32'h50, 32'h77777777, 1, 0, 1, 100);
    check_comb("midreset_sw", 0, 4'b0000, 32'h0, 32'h50);
    exp_q.push_back(32'h0);
    check_w("midreset", 1);

    // halt and reset together behave like reset.
    drive(SW, 32'h60, 32'h66666666, 1, 1, 1, 101);
    check_comb("halt_reset_sw", 0, 4'b0000, 32'h0, 32'h60);
    exp_q.push_back(32'h0);
    check_w("halt_reset", 1);

    // Every previously written word must now read zero.
    drive(LW, 32'h10, 32'h0, 1, 0, 0, 102);
    exp_q.push_back(32'h0);
    check_w("cleared_10", 0);
    drive(LW, 32'h20, 32'h0, 1, 0, 0, 103);
    exp_q.push_back(32'h0);
    check_w("cleared_20", 0);
    drive(LW, 32'h2FFC, 32'h0, 1, 0, 0, 104);
    exp_q.push_back(32'h0);
    check_w("cleared_2ffc", 0);
    drive(LW, 32'h50, 32'h0, 1, 0, 0, 105);
    exp_q.push_back(32'h0);
    check_w("cleared_50", 0);
    drive(LW, 32'h60, 32'h0, 1, 0, 0, 106);
    exp_q.push_back(32'h0);
    check_w("cleared_60", 0);

    // Back-to-back store then load after reset still works.
    drive(SB, 32'h53, 32'h000000C3, 1, 0, 0, 107);
    check_comb("post_sb", 1, 4'b1000, 32'hC3000000, 32'h53);
    exp_q.push_back(32'h0);
    check_w("post_sb", 0);
    drive(LB, 32'h53, 32'h0, 1, 0, 0, 108);
    exp_q.push_back(32'hFFFFFFC3);
    check_w("post_lb", 0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
